// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: data-memory FSM state encoding, word width and default latency.
package pipeline_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int WORD_W          = 32;
    localparam int DEFAULT_LATENCY = 3;

endpackage : pipeline_pkg

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the EX/MEM register side and the data-memory responder.
interface dmem_responder_if;
    import pipeline_pkg::*;

    logic              r_valid;
    logic              w_valid;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              stall;
    logic              busy;

    modport master (
        output r_valid, w_valid, addr, wdata,
        input  rdata, stall, busy
    );

    modport slave (
        input  r_valid, w_valid, addr, wdata,
        output rdata, stall, busy
    );
endinterface : dmem_responder_if

// File: rtl/dmem_array.sv
// Word-addressed 32-bit memory with one synchronous write port and one synchronous read port; no reset.
module dmem_array
    import pipeline_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WORD_W-1:0]     wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem_r [0:(2**ADDR_WIDTH)-1];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: the output register only moves when a load is performed
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: FSM, latency counter and pipeline stall around a dmem_array.
module dmem_responder
    import pipeline_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = DEFAULT_LATENCY
) (
    input  logic             clk,
    input  logic             rstn,
    dmem_responder_if.slave  bus
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be >= 1");
    end

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic                  busy_r;
    logic                  rd_seen_r;
    logic                  req_s;
    logic                  perform_s;
    logic                  we_s;
    logic                  re_s;
    logic [ADDR_WIDTH-1:0] word_s;
    logic [WORD_W-1:0]     arr_rdata_s;
    logic                  unused_addr_s;

    assign req_s         = bus.r_valid | bus.w_valid;
    assign word_s        = bus.addr[ADDR_WIDTH+1:2];
    assign unused_addr_s = ^{bus.addr[WORD_W-1:ADDR_WIDTH+2], bus.addr[1:0]};

    // Next-state, counter and access-strobe logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        perform_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s && (LATENCY == 1)) begin
                    perform_s   = 1'b1;
                    state_nxt_s = DONE;
                end else if (req_s) begin
                    cnt_nxt_s   = CNT_W'(LATENCY - 1);
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_W'(1)) begin
                    perform_s   = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // A simultaneous load+store is treated as a store only
    assign we_s = perform_s & bus.w_valid;
    assign re_s = perform_s & bus.r_valid & ~bus.w_valid;

    // State, counter and registered status
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            rd_seen_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
            rd_seen_r <= rd_seen_r | re_s;
        end
    end

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (we_s),
        .waddr (word_s),
        .wdata (bus.wdata),
        .re    (re_s),
        .raddr (word_s),
        .rdata (arr_rdata_s)
    );

    // Gating with rstn keeps stall low while a request is held during reset
    assign bus.stall = rstn & (((state_r == IDLE) & req_s) | (state_r == BUSY));
    assign bus.busy  = busy_r;
    assign bus.rdata = rd_seen_r ? arr_rdata_s : {WORD_W{1'b0}};

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder at LATENCY=3 and LATENCY=1.
module tb_dmem_responder;

    logic clk;
    logic rstn;
    int   pass_cnt;
    int   total_cnt;

    dmem_responder_if bus3 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.ADDR_WIDTH(8), .LATENCY(3)) u_dut3 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus3.slave)
    );

    dmem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u_dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drives one request on the LATENCY=3 instance and returns in its DONE cycle
    task automatic run3(input string tag, input logic rv, input logic wv,
                        input logic [31:0] a, input logic [31:0] d);
        int n;
        bus3.r_valid = rv;
        bus3.w_valid = wv;
        bus3.addr    = a;
        bus3.wdata   = d;
        #1;
        chk({tag, "_busy_t0"}, 32'(bus3.busy), 32'd0);
        n = 0;
        while (bus3.stall && n < 10) begin
            n++;
            tick();
        end
        chk({tag, "_stall_cycles"}, 32'(n), 32'd3);
        chk({tag, "_busy_done"}, 32'(bus3.busy), 32'd1);
    endtask

    task automatic idle3();
        bus3.r_valid = 1'b0;
        bus3.w_valid = 1'b0;
        bus3.addr    = 32'h0;
        bus3.wdata   = 32'h0;
    endtask

    initial begin
        logic [3:0] pat;
        pass_cnt  = 0;
        total_cnt = 0;
        rstn = 1'b0;
        idle3();
        bus3.r_valid = 1'b1;
        bus1.r_valid = 1'b1;
        bus1.w_valid = 1'b0;
        bus1.addr    = 32'h0;
        bus1.wdata   = 32'h0;

        // Reset with a pending load
        #3;
        chk("rst_stall3", 32'(bus3.stall), 32'd0);
        chk("rst_busy3",  32'(bus3.busy),  32'd0);
        chk("rst_rdata3", bus3.rdata,      32'h0);
        chk("rst_stall1", 32'(bus1.stall), 32'd0);
        tick();
        tick();
        bus3.r_valid = 1'b0;
        bus1.r_valid = 1'b0;
        rstn = 1'b1;
        tick();
        chk("idle_stall", 32'(bus3.stall), 32'd0);
        chk("idle_busy",  32'(bus3.busy),  32'd0);
        tick();
        chk("idle_hold_busy", 32'(bus3.busy), 32'd0);

        // Store then back-to-back load
        run3("st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        chk("st10_rdata_unchanged", bus3.rdata, 32'h0);
        tick();
        run3("ld10", 1'b1, 1'b0, 32'h10, 32'h0);
        chk("ld10_rdata", bus3.rdata, 32'hDEADBEEF);
        tick();
        idle3();
        #1;
        chk("after_ld_busy",  32'(bus3.busy),  32'd0);
        chk("after_ld_stall", 32'(bus3.stall), 32'd0);

        // Simultaneous load+store, then aliased load
        run3("both20", 1'b1, 1'b1, 32'h20, 32'h1234);
        chk("both20_rdata_kept", bus3.rdata, 32'hDEADBEEF);
        tick();
        run3("ld23", 1'b1, 1'b0, 32'h23, 32'h0);
        chk("ld23_rdata", bus3.rdata, 32'h1234);
        tick();

        // Address wrap
        run3("st400", 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
        tick();
        run3("ld0", 1'b1, 1'b0, 32'h0, 32'h0);
        chk("ld0_wrap_rdata", bus3.rdata, 32'hA5A5A5A5);
        tick();

        // Reset mid-access discards the pending store
        run3("st30_zero", 1'b0, 1'b1, 32'h30, 32'h0);
        tick();
        bus3.w_valid = 1'b1;
        bus3.addr    = 32'h30;
        bus3.wdata   = 32'h55;
        tick();
        tick();
        chk("mid_busy_before", 32'(bus3.busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(bus3.stall), 32'd0);
        chk("mid_rst_busy",  32'(bus3.busy),  32'd0);
        idle3();
        tick();
        rstn = 1'b1;
        tick();
        run3("ld30", 1'b1, 1'b0, 32'h30, 32'h0);
        chk("ld30_rdata", bus3.rdata, 32'h0);
        tick();
        idle3();

        // LATENCY=1: store, then two back-to-back loads
        bus1.w_valid = 1'b1;
        bus1.addr    = 32'h4;
        bus1.wdata   = 32'h77;
        #1;
        chk("l1_st_stall", 32'(bus1.stall), 32'd1);
        tick();
        chk("l1_st_done_stall", 32'(bus1.stall), 32'd0);
        tick();
        bus1.w_valid = 1'b0;
        bus1.r_valid = 1'b1;
        #1;
        pat[3] = bus1.stall;
        tick();
        pat[2] = bus1.stall;
        chk("l1_ld1_rdata", bus1.rdata, 32'h77);
        tick();
        bus1.addr = 32'h10;
        #1;
        pat[1] = bus1.stall;
        tick();
        pat[0] = bus1.stall;
        chk("l1_stall_pattern", 32'(pat), 32'hA);
        tick();
        bus1.r_valid = 1'b0;
        #1;
        chk("l1_idle_busy", 32'(bus1.busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_dmem_responder

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the MEM-stage load/store requests (`r_valid`/`w_valid`) issued from the EX/MEM pipeline register. It holds a word-addressed memory with a fixed, parameterized access latency, and it drives `stall` back to the pipeline registers until each access completes. It sits between the EX/MEM register outputs and the MEM/WB register `mdr` input, on the memory end of the request interface.

## Interface

Parameters:
- `ADDR_WIDTH`, default 8: word-address bits, giving 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 3: number of stall cycles per access. Must be ≥1; values ≤0 are illegal and elaborate as an error.

Ports (clock and reset first):
- `clk`  in  1: the single clock; all state is rising-edge.
- `rstn`  in  1: reset, asynchronous and active-low.
- `r_valid`  in  1: load request, held stable while `stall`=1.
- `w_valid`  in  1: store request, held stable while `stall`=1.
- `addr`  in  32: byte address. Bits [1:0] are ignored; bits [ADDR_WIDTH+1:2] form the word index.
- `wdata`  in  32: store data.
- `rdata`  out  32: load data, registered.
- `stall`  out  1: freeze request to the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- `busy`  out  1: registered; high while state ≠ IDLE.

## Operation

- `req` = `r_valid` | `w_valid`.
- The FSM has three states: IDLE, BUSY and DONE. The down-counter `cnt` is $clog2(LATENCY+1) bits wide.
- IDLE:
  - With `req`=0, stay in IDLE.
  - With `req`=1 and LATENCY=1, perform the access and go to DONE.
  - With `req`=1 and LATENCY>1, load `cnt`=LATENCY-1 and go to BUSY.
- BUSY:
  - With `cnt`=1, perform the access and go to DONE.
  - Otherwise decrement `cnt`.
  - `req` is not re-sampled in BUSY; the requester is frozen by `stall`.
- DONE: go to IDLE unconditionally. The request still visible in DONE is the completed one and is not re-issued.
- Performing the access:
  - Store: write `wdata` to `mem[word]`.
  - Load: `rdata` ← `mem[word]`.
  - `r_valid` and `w_valid` both high: the store is performed and `rdata` is left unchanged.
- `stall` is combinational: (IDLE & `req`) | BUSY. It is low in DONE.
- `rdata` holds its value until the next load completes. A store never changes `rdata`.
- Address wrap: word index bits above ADDR_WIDTH+1 are discarded, so `addr` 0x400 with ADDR_WIDTH=8 maps to word 0.
- Reset values: state=IDLE, `cnt`=0, `rdata`=0, `busy`=0, `stall`=0.
- Memory contents are not reset.
- Reset mid-access (`rstn` low in BUSY): return to IDLE immediately. A store that has not yet been performed is discarded and memory is unchanged.

## Timing

- Request appears in cycle T0 (IDLE).
- `stall`=1 in cycles T0 … T(LATENCY-1).
- DONE is cycle T(LATENCY), with `stall`=0. `rdata` is valid in DONE, so MEM/WB captures it at the end of DONE.
- The write commits at the clock edge ending T(LATENCY-1).
- Occupancy is LATENCY+1 cycles per access.
- Back-to-back requests: the next request is seen in IDLE at T(LATENCY+1). There is no lost cycle beyond DONE.
- No-request cycles: `stall`=0 and there is no state change.
- `busy` goes high at the edge ending T0 and low at the edge ending DONE.

## Structure

- Shared package `pipeline_pkg`:
  - state encoding localparams: IDLE=2'd0, BUSY=2'd1, DONE=2'd2
  - `WORD_W`=32
  - default `LATENCY` constant
- One sub-module, `dmem_array`:
  - parameter `ADDR_WIDTH`
  - synchronous write port (`we`, `waddr`, `wdata`) and synchronous read port (`re`, `raddr`, `rdata`)
  - no reset
- `dmem_responder` contains only the FSM, counter and stall logic, and instantiates `dmem_array`. `re`/`we` are asserted only in the perform cycle.

## Test plan

All scenarios use LATENCY=3 and ADDR_WIDTH=8 unless stated.

- **Reset:** `rstn`=0 with `r_valid`=1 → `stall`=0 (`req` ignored while in reset), `busy`=0, `rdata`=0. After release, state=IDLE.
- **Store then load:** store 0xDEADBEEF to 0x10 → `stall`=1 for exactly 3 cycles, then low in DONE. Load 0x10 → `rdata`=0xDEADBEEF in its DONE cycle, stall for 3 cycles. Total occupancy is 8 cycles with no gap.
- **Simultaneous request and alias:** `r_valid`=`w_valid`=1, `addr`=0x20, `wdata`=0x1234 → `rdata` keeps its previous value (0xDEADBEEF). A later load of 0x23 (low bits ignored) returns 0x1234.
- **Address wrap:** store 0xA5A5A5A5 to 0x400 → load 0x0 returns 0xA5A5A5A5.
- **Reset mid-access:** store 0x55 to 0x30 (prior contents 0x0). Pull `rstn` low in the second BUSY cycle → `stall`=0 and `busy`=0 immediately. After release, a load of 0x30 returns 0x0.
- **LATENCY=1:** two back-to-back loads → `stall` high exactly one cycle each, DONE in the next cycle, with the `stall` pattern 1,0,1,0.
